// File: rtl/alu_mul_seq_pkg.sv
// Shared types for the p18240 datapath: ALU opcodes, multiplier sequencer
// states, and the helper that packs condition codes in ZCNV order.
package alu_mul_seq_pkg;

    typedef enum logic [2:0] {
        F_A         = 3'd0,
        F_A_PLUS_B  = 3'd1,
        F_A_MINUS_B = 3'd2,
        F_A_AND_B   = 3'd3,
        F_A_OR_B    = 3'd4,
        F_A_XOR_B   = 3'd5,
        F_B         = 3'd6,
        F_NOT_A     = 3'd7
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } mul_state_t;

    localparam int unsigned DATA_W = 16;

    // Pack {Z, C, N, V}; V is always 0 for an unsigned product.
    function automatic logic [3:0] make_cc(input logic [DATA_W-1:0] result,
                                           input logic carry);
        make_cc = {(result == 16'd0), carry, result[DATA_W-1], 1'b0};
    endfunction

endpackage

// File: rtl/alu_mul_seq_alu.sv
// Combinational 16-bit ALU used for the accumulate step of the multiplier.
module alu_mul_seq_alu
    import alu_mul_seq_pkg::*;
(
    input  logic [15:0] inA_i,
    input  logic [15:0] inB_i,
    input  alu_op_t     op_i,
    output logic [15:0] out_o,
    output logic        carry_o
);

    logic [16:0] sum_s;

    // Operation decode; carry is only meaningful for add/subtract.
    always_comb begin
        sum_s   = 17'd0;
        out_o   = inA_i;
        carry_o = 1'b0;
        case (op_i)
            F_A: begin
                out_o = inA_i;
            end
            F_A_PLUS_B: begin
                sum_s   = {1'b0, inA_i} + {1'b0, inB_i};
                out_o   = sum_s[15:0];
                carry_o = sum_s[16];
            end
            F_A_MINUS_B: begin
                sum_s   = {1'b0, inA_i} + {1'b0, ~inB_i} + 17'd1;
                out_o   = sum_s[15:0];
                carry_o = sum_s[16];
            end
            F_A_AND_B: begin
                out_o = inA_i & inB_i;
            end
            F_A_OR_B: begin
                out_o = inA_i | inB_i;
            end
            F_A_XOR_B: begin
                out_o = inA_i ^ inB_i;
            end
            F_B: begin
                out_o = inB_i;
            end
            F_NOT_A: begin
                out_o = ~inA_i;
            end
            default: begin
                out_o   = inA_i;
                carry_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_mul_seq.sv
// Shift-and-add sequencer producing the low 16 bits of a 16x16 unsigned
// product, one ALU add per multiplier bit, with sticky overflow tracking.
module alu_mul_seq
    import alu_mul_seq_pkg::*;
(
    input  logic        clock,
    input  logic        reset_L,
    input  logic        start,
    input  logic [15:0] mcand,
    input  logic [15:0] mplier,
    output logic        busy,
    output logic        done,
    output logic [15:0] product,
    output logic [3:0]  condCodes
);

    mul_state_t  state_q, state_d;
    logic [15:0] acc_q, acc_d;
    logic [15:0] mc_q, mc_d;
    logic [15:0] mp_q, mp_d;
    logic        lost_q, lost_d;
    logic        ovf_q, ovf_d;
    logic [15:0] product_q, product_d;
    logic [3:0]  cc_q, cc_d;
    logic        busy_q;
    logic        done_q;

    logic [15:0] alu_out_s;
    logic        alu_carry_s;

    alu_mul_seq_alu u_alu (
        .inA_i   (acc_q),
        .inB_i   (mc_q),
        .op_i    (F_A_PLUS_B),
        .out_o   (alu_out_s),
        .carry_o (alu_carry_s)
    );

    // Next-state and datapath update; results latch on the edge entering DONE.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        mc_d      = mc_q;
        mp_d      = mp_q;
        lost_d    = lost_q;
        ovf_d     = ovf_q;
        product_d = product_q;
        cc_d      = cc_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d   = 16'd0;
                    mc_d    = mcand;
                    mp_d    = mplier;
                    lost_d  = 1'b0;
                    ovf_d   = 1'b0;
                    state_d = (mplier != 16'd0) ? CALC : DONE;
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                if (mp_q[0]) begin
                    acc_d = alu_out_s;
                    // A multiplicand bit already shifted out would have landed
                    // above bit 15, so it counts as overflow once it is added.
                    ovf_d = ovf_q | alu_carry_s | lost_q;
                end else begin
                    acc_d = acc_q;
                    ovf_d = ovf_q;
                end
                mc_d   = {mc_q[14:0], 1'b0};
                lost_d = lost_q | mc_q[15];
                mp_d   = {1'b0, mp_q[15:1]};
                if (mp_q[15:1] == 15'd0) begin
                    state_d = DONE;
                end else begin
                    state_d = CALC;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (state_d == DONE) begin
            product_d = acc_d;
            cc_d      = make_cc(acc_d, ovf_d);
        end else begin
            product_d = product_q;
            cc_d      = cc_q;
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset_L) begin
            state_q   <= IDLE;
            acc_q     <= 16'd0;
            mc_q      <= 16'd0;
            mp_q      <= 16'd0;
            lost_q    <= 1'b0;
            ovf_q     <= 1'b0;
            product_q <= 16'd0;
            cc_q      <= 4'b0000;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            mc_q      <= mc_d;
            mp_q      <= mp_d;
            lost_q    <= lost_d;
            ovf_q     <= ovf_d;
            product_q <= product_d;
            cc_q      <= cc_d;
            busy_q    <= (state_d == CALC);
            done_q    <= (state_d == DONE);
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign product   = product_q;
    assign condCodes = cc_q;

endmodule
